// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry (main + skid) output buffer; extension is done at accept time.
// Optional accepted-item counter on perf_cnt when IMM_EXT_PERF_EN is defined.
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
`ifdef IMM_EXT_PERF_EN
   ,
   output logic [15:0]      perf_cnt
`endif
);

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [1:0] mode);
      logic [OUT_W-1:0] sext;
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (mode)
         2'b00:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
         2'b01:   extend = sext;
         2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
         default: extend = {sext[OUT_W-3:0], 2'b00};
      endcase
   endfunction

   logic [1:0]       cnt_q, cnt_d;
   logic [OUT_W-1:0] head_data_q, head_data_d;
   logic [TAG_W-1:0] head_tag_q, head_tag_d;
   logic [OUT_W-1:0] skid_data_q, skid_data_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             acc, xfer;
   logic [OUT_W-1:0] new_data;

   assign in_ready  = (cnt_q < 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign acc       = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   assign new_data  = extend(in_imm, in_mode);

   // Head register drives the outputs directly; it is zeroed whenever the buffer empties.
   assign out_data = head_data_q;
   assign out_tag  = head_tag_q;
   assign out_neg  = head_data_q[OUT_W-1];

   always_comb begin
      cnt_d       = cnt_q;
      head_data_d = head_data_q;
      head_tag_d  = head_tag_q;
      skid_data_d = skid_data_q;
      skid_tag_d  = skid_tag_q;
      if (flush) begin
         cnt_d       = 2'd0;
         head_data_d = '0;
         head_tag_d  = '0;
         skid_data_d = '0;
         skid_tag_d  = '0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (acc) begin
                  head_data_d = new_data;
                  head_tag_d  = in_tag;
                  cnt_d       = 2'd1;
               end
            end
            2'd1: begin
               if (acc && xfer) begin
                  head_data_d = new_data;
                  head_tag_d  = in_tag;
               end else if (acc) begin
                  skid_data_d = new_data;
                  skid_tag_d  = in_tag;
                  cnt_d       = 2'd2;
               end else if (xfer) begin
                  head_data_d = '0;
                  head_tag_d  = '0;
                  cnt_d       = 2'd0;
               end
            end
            2'd2: begin
               // in_ready is low here, so only a drain into the head can happen
               if (xfer) begin
                  head_data_d = skid_data_q;
                  head_tag_d  = skid_tag_q;
                  skid_data_d = '0;
                  skid_tag_d  = '0;
                  cnt_d       = 2'd1;
               end
            end
            default: cnt_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= 2'd0;
         head_data_q <= '0;
         head_tag_q  <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         head_data_q <= head_data_d;
         head_tag_q  <= head_tag_d;
         skid_data_q <= skid_data_d;
         skid_tag_q  <= skid_tag_d;
      end
   end

`ifdef IMM_EXT_PERF_EN
   logic [15:0] perf_q;

   // Counts every handshake, including one whose item a same-cycle flush discards.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (acc && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: driver issues directed and random items with their expected
// results, the monitor tracks buffer contents in a queue and compares every cycle.
module tb_imm_ext_pipe;

   logic        clk;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_neg;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;
`ifdef IMM_EXT_PERF_EN
   logic [15:0] perf_cnt;
`endif

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .out_neg(out_neg)
`ifdef IMM_EXT_PERF_EN
      , .perf_cnt(perf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
   } item_t;

   item_t       q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] drv_exp_d;
   logic [4:0]  drv_exp_t;
   logic        done;
   logic        drv_to;

   // Reference: value of the immediate as an integer, then scaled, then reduced modulo 2^32.
   function automatic logic [31:0] ref_ext(input int unsigned imm, input int mode);
      longint s, v;
      s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
      case (mode)
         0:       v = longint'(imm);
         1:       v = s;
         2:       v = longint'(imm) * 65536;
         default: v = s * 4;
      endcase
      v = v % 64'sd4294967296;
      if (v < 0) v = v + 64'sd4294967296;
      return v[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                        input logic [31:0] exp);
      logic a;
      in_valid  = 1'b1;
      in_imm    = imm;
      in_mode   = mode;
      in_tag    = tag;
      drv_exp_d = exp;
      drv_exp_t = tag;
      for (int k = 0; k < 16; k++) begin
         a = in_ready;
         step();
         if (a) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      drv_to   = 1'b1;
   endtask

   task automatic offer_rand(input logic [4:0] tag);
      logic [15:0] imm;
      logic [1:0]  mode;
      imm  = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      offer(imm, mode, tag, ref_ext(int'(imm), int'(mode)));
   endtask

   // Driver
   initial begin
      logic [15:0] imm;
      logic [1:0]  mode;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_imm = '0; in_mode = '0; in_tag = '0;
      drv_exp_d = '0; drv_exp_t = '0; done = 1'b0; drv_to = 1'b0;
      step(); step();
      rst = 1'b0;

      // Known-answer vectors
      out_ready = 1'b1;
      offer(16'h8004, 2'b01, 5'd1, 32'hFFFF8004);
      offer(16'h8004, 2'b00, 5'd2, 32'h00008004);
      offer(16'h1234, 2'b10, 5'd3, 32'h12340000);
      offer(16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC);
      offer(16'h4000, 2'b11, 5'd5, 32'h00010000);
      step(); step();

      // Backpressure: third offer refused until the consumer drains
      out_ready = 1'b0;
      offer_rand(5'd1);
      offer_rand(5'd2);
      in_valid = 1'b1; in_imm = 16'h00F3; in_mode = 2'b01; in_tag = 5'd3;
      drv_exp_d = ref_ext(32'h00F3, 1); drv_exp_t = 5'd3;
      step();
      out_ready = 1'b1;
      offer(16'h00F3, 2'b01, 5'd3, ref_ext(32'h00F3, 1));
      repeat (4) step();

      // Flush when full with a same-cycle offer, then flush at occupancy 1 with an accept
      out_ready = 1'b0;
      offer_rand(5'd10);
      offer_rand(5'd11);
      in_valid = 1'b1; in_imm = 16'h7777; in_mode = 2'b00; in_tag = 5'd12;
      drv_exp_d = 32'h7777; drv_exp_t = 5'd12;
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      offer_rand(5'd13);
      in_valid = 1'b1; in_tag = 5'd14; drv_exp_t = 5'd14;
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step(); step();

      // Reset with one item buffered
      offer_rand(5'd15);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step(); step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         imm       = 16'($urandom);
         mode      = 2'($urandom_range(0, 3));
         in_imm    = imm;
         in_mode   = mode;
         in_tag    = 5'($urandom);
         drv_exp_d = ref_ext(int'(imm), int'(mode));
         drv_exp_t = in_tag;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

`ifdef IMM_EXT_PERF_EN
      // Saturation of the accept counter; flush must leave it alone
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 0; c < 70000; c++) begin
         imm       = 16'($urandom);
         mode      = 2'($urandom_range(0, 3));
         in_imm    = imm;
         in_mode   = mode;
         in_tag    = 5'($urandom);
         drv_exp_d = ref_ext(int'(imm), int'(mode));
         drv_exp_t = in_tag;
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush = 1'b0;
`endif

      out_ready = 1'b1;
      repeat (6) step();
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      int          occ;
      logic [15:0] pm;
      pm = '0;
      forever begin
         @(negedge clk);
         if (done) break;
         occ = q.size();
         chk("in_ready", 64'(in_ready), 64'(occ < 2));
         chk("out_valid", 64'(out_valid), 64'(occ != 0));
         if (occ != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_tag", 64'(out_tag), 64'(q[0].t));
            chk("out_neg", 64'(out_neg), 64'(q[0].d >= 32'h8000_0000));
         end else begin
            chk("idle_data", 64'(out_data), 64'd0);
            chk("idle_tag", 64'(out_tag), 64'd0);
            chk("idle_neg", 64'(out_neg), 64'd0);
         end
`ifdef IMM_EXT_PERF_EN
         chk("perf_cnt", 64'(perf_cnt), 64'(pm));
`endif
         if (rst) begin
            q.delete();
            pm = '0;
         end else begin
            if (in_valid && (occ < 2) && (pm != 16'hFFFF)) pm = pm + 16'd1;
            if ((occ != 0) && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && (occ < 2)) q.push_back('{d: drv_exp_d, t: drv_exp_t});
         end
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("offer_timeout", 64'(drv_to), 64'd0);
`ifdef IMM_EXT_PERF_EN
      chk("perf_saturated", 64'(perf_cnt), 64'hFFFF);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate field width.
REQ-002 Parameter OUT_W, default 32, extended result width; legal only when OUT_W >= IN_W+2.
REQ-003 Parameter TAG_W, default 5, sideband tag width (e.g. destination register) carried with each item.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all buffered items.
REQ-007 in_valid  input  1  producer offers an item.
REQ-008 in_ready  output  1  block can accept an item this cycle.
REQ-009 in_imm  input  IN_W  raw immediate.
REQ-010 in_mode  input  2  00 zero-ext, 01 sign-ext, 10 upper (imm << (OUT_W-IN_W)), 11 sign-ext then << 2 (branch offset).
REQ-011 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 out_data  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of the item on out_data.
REQ-016 out_neg  output  1  out_data[OUT_W-1] of the current item.

Function
REQ-017 Accept occurs when in_valid && in_ready at a rising edge; transfer occurs when out_valid && out_ready at a rising edge.
REQ-018 Storage: 2-entry FIFO (main + skid); in_ready = (occupancy < 2), a registered-state function with no combinational path from out_ready.
REQ-019 Latency: item accepted at edge N appears on out_* after edge N when FIFO was empty; otherwise strictly in order.
REQ-020 Extension computed at accept and stored; out_data, out_tag, out_neg stable while out_valid && !out_ready.
REQ-021 Mode 00: upper OUT_W-IN_W bits zero.
REQ-022 Mode 01: upper bits replicate in_imm[IN_W-1].
REQ-023 Mode 10: in_imm in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-024 Mode 11: sign-extended value shifted left 2, bits above OUT_W-1 dropped, bits [1:0] zero.
REQ-025 Simultaneous accept and transfer with occupancy 1 or 2: occupancy unchanged, order preserved; with occupancy 2 in_ready is low so no accept occurs.
REQ-026 Empty: out_valid low, out_data/out_tag/out_neg hold 0.
REQ-027 flush: occupancy becomes 0 at that edge; a same-cycle accept is discarded; a same-cycle transfer is still counted as taken by the consumer.
REQ-028 Occupancy never exceeds 2 nor underflows; out_ready with out_valid low has no effect.

Reset
REQ-029 rst high at an edge: occupancy 0, out_valid 0, out_data/out_tag/out_neg 0, in_ready 1 after the edge.
REQ-030 rst has priority over flush, accept and transfer; reset mid-stream drops all buffered items.

Configuration
REQ-031 Macro IMM_EXT_PERF_EN defined: adds output perf_cnt (16 bits) counting accepted items, saturating at 0xFFFF, cleared by rst only (not by flush).
REQ-032 Macro IMM_EXT_PERF_EN undefined: perf_cnt port and counter absent; all other behaviour identical.

Verification
REQ-033 Defaults, mode 01, in_imm=0x8004, out_ready=1 -> next cycle out_data=0xFFFF8004, out_neg=1; mode 00 same imm -> 0x00008004, out_neg=0.
REQ-034 Mode 10 in_imm=0x1234 -> 0x12340000; mode 11 in_imm=0xFFFF -> 0xFFFFFFFC; mode 11 in_imm=0x4000 -> 0x00010000.
REQ-035 out_ready=0, three back-to-back offers tags 1,2,3 -> tags 1,2 accepted, in_ready low on third; release out_ready -> tags 1,2,3 delivered in order, none lost or duplicated.
REQ-036 Occupancy 2, flush with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, flushed and offered items never appear.
REQ-037 rst asserted with occupancy 1 -> all outputs 0, in_ready=1; with IMM_EXT_PERF_EN, 70000 accepts -> perf_cnt=0xFFFF, flush leaves it unchanged.
